// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / character-out bus of the PS/2 set-2 scancode decoder.
// The master side feeds scancode bytes and consumes characters; the slave side is the decoder.
interface ps2_scancode_decoder_if;
    logic [7:0] ps2_received_data;
    logic       ps2_received_data_strb;
    logic [7:0] ascii_data;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       overflow;

    modport master (
        output ps2_received_data, ps2_received_data_strb, ascii_ready,
        input  ascii_data, ascii_valid, overflow
    );

    modport slave (
        input  ps2_received_data, ps2_received_data_strb, ascii_ready,
        output ascii_data, ascii_valid, overflow
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 make-code to ASCII decoder with a one-entry valid/ready holding register.
// Optional feature: define PS2_LOWERCASE_EN to track shift and emit lowercase letters.
module ps2_scancode_decoder (
    input  logic                          clk,
    input  logic                          rst_n,
    ps2_scancode_decoder_if.slave         bus
);
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   ascii_data_q, ascii_data_d;
    logic                ascii_valid_q, ascii_valid_d;
    logic                overflow_q, overflow_d;
`ifdef PS2_LOWERCASE_EN
    logic                shift_q, shift_d;
`endif

    logic                xfer;
    logic                new_char;
    logic [DATA_W:0]     mapped;
    logic [DATA_W-1:0]   char_out;

    // Returns {hit, uppercase ascii} for a make code.
    function automatic logic [DATA_W:0] map_code(input logic [DATA_W-1:0] code);
        logic [DATA_W:0] r;
        r = '0;
        case (code)
            8'h1C: r = {1'b1, 8'h41}; 8'h32: r = {1'b1, 8'h42}; 8'h21: r = {1'b1, 8'h43};
            8'h23: r = {1'b1, 8'h44}; 8'h24: r = {1'b1, 8'h45}; 8'h2B: r = {1'b1, 8'h46};
            8'h34: r = {1'b1, 8'h47}; 8'h33: r = {1'b1, 8'h48}; 8'h43: r = {1'b1, 8'h49};
            8'h3B: r = {1'b1, 8'h4A}; 8'h42: r = {1'b1, 8'h4B}; 8'h4B: r = {1'b1, 8'h4C};
            8'h3A: r = {1'b1, 8'h4D}; 8'h31: r = {1'b1, 8'h4E}; 8'h44: r = {1'b1, 8'h4F};
            8'h4D: r = {1'b1, 8'h50}; 8'h15: r = {1'b1, 8'h51}; 8'h2D: r = {1'b1, 8'h52};
            8'h1B: r = {1'b1, 8'h53}; 8'h2C: r = {1'b1, 8'h54}; 8'h3C: r = {1'b1, 8'h55};
            8'h2A: r = {1'b1, 8'h56}; 8'h1D: r = {1'b1, 8'h57}; 8'h22: r = {1'b1, 8'h58};
            8'h35: r = {1'b1, 8'h59}; 8'h1A: r = {1'b1, 8'h5A};
            8'h45: r = {1'b1, 8'h30}; 8'h16: r = {1'b1, 8'h31}; 8'h1E: r = {1'b1, 8'h32};
            8'h26: r = {1'b1, 8'h33}; 8'h25: r = {1'b1, 8'h34}; 8'h2E: r = {1'b1, 8'h35};
            8'h36: r = {1'b1, 8'h36}; 8'h3D: r = {1'b1, 8'h37}; 8'h3E: r = {1'b1, 8'h38};
            8'h46: r = {1'b1, 8'h39};
            8'h29: r = {1'b1, 8'h20}; 8'h5A: r = {1'b1, 8'h0D}; 8'h66: r = {1'b1, 8'h08};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Next-state, holding register and overflow logic.
    always_comb begin
        state_d       = state_q;
        ascii_data_d  = ascii_data_q;
        ascii_valid_d = ascii_valid_q;
        overflow_d    = overflow_q;
`ifdef PS2_LOWERCASE_EN
        shift_d       = shift_q;
`endif
        new_char      = 1'b0;
        xfer          = ascii_valid_q & bus.ascii_ready;
        mapped        = map_code(bus.ps2_received_data);
        char_out      = mapped[DATA_W-1:0];
`ifdef PS2_LOWERCASE_EN
        if (!shift_q && char_out >= 8'h41 && char_out <= 8'h5A)
            char_out = DATA_W'(char_out + 8'h20);
`endif

        if (bus.ps2_received_data_strb) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.ps2_received_data == 8'hF0)      state_d = BREAK;
                    else if (bus.ps2_received_data == 8'hE0) state_d = EXT;
                    else begin
                        state_d  = IDLE;
                        new_char = mapped[DATA_W];
`ifdef PS2_LOWERCASE_EN
                        if (bus.ps2_received_data == 8'h12 || bus.ps2_received_data == 8'h59)
                            shift_d = 1'b1;
`endif
                    end
                end
                BREAK: begin
                    state_d = IDLE;
`ifdef PS2_LOWERCASE_EN
                    if (bus.ps2_received_data == 8'h12 || bus.ps2_received_data == 8'h59)
                        shift_d = 1'b0;
`endif
                end
                EXT:       state_d = (bus.ps2_received_data == 8'hF0) ? EXT_BREAK : IDLE;
                EXT_BREAK: state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end

        if (xfer) ascii_valid_d = 1'b0;
        // A draining register may be reloaded in the same cycle.
        if (new_char) begin
            if (!ascii_valid_q || xfer) begin
                ascii_data_d  = char_out;
                ascii_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ascii_data_q  <= '0;
            ascii_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
`ifdef PS2_LOWERCASE_EN
            shift_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ascii_data_q  <= ascii_data_d;
            ascii_valid_q <= ascii_valid_d;
            overflow_q    <= overflow_d;
`ifdef PS2_LOWERCASE_EN
            shift_q       <= shift_d;
`endif
        end
    end

    assign bus.ascii_data  = ascii_data_q;
    assign bus.ascii_valid = ascii_valid_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: directed scenarios then random byte/ready traffic.
// Honours PS2_LOWERCASE_EN the same way as the design.
module tb_ps2_scancode_decoder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ps2_scancode_decoder_if bus ();
    ps2_scancode_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Scancode table: 26 letters, 10 digits, space, enter, backspace.
    logic [7:0] codes [39] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
        8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
        8'h29, 8'h5A, 8'h66};

    // Reference model: prefix flags, shift, holding register and expected character stream.
    bit m_brk = 0, m_ext = 0, m_shift = 0;
    bit m_valid = 0, m_ovf = 0, n_valid = 0, n_ovf = 0;
    int m_data = 0, n_data = 0;
    int exp_q [$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lookup(input logic [7:0] b);
        int v;
        for (int i = 0; i < 39; i++) begin
            if (codes[i] == b) begin
                if (i < 26) begin
                    v = 'h41 + i;
`ifdef PS2_LOWERCASE_EN
                    if (!m_shift) v = v + 'h20;
`endif
                end else if (i < 36) v = 'h30 + (i - 26);
                else if (i == 36)    v = 'h20;
                else if (i == 37)    v = 'h0D;
                else                 v = 'h08;
                return v;
            end
        end
        return -1;
    endfunction

    // Character produced by one received byte, or -1.
    function automatic int model_byte(input logic [7:0] b);
        if (m_ext) begin
            if (!m_brk && b == 8'hF0) m_brk = 1;
            else begin m_ext = 0; m_brk = 0; end
            return -1;
        end
        if (m_brk) begin
            m_brk = 0;
            if (b == 8'h12 || b == 8'h59) m_shift = 0;
            return -1;
        end
        if (b == 8'hF0) begin m_brk = 1; return -1; end
        if (b == 8'hE0) begin m_ext = 1; return -1; end
        if (b == 8'h12 || b == 8'h59) m_shift = 1;
        return lookup(b);
    endfunction

    // One clock: commit model, drive inputs, predict the effect of the next edge.
    task automatic cyc(input bit rn, input logic [7:0] b, input bit s, input bit r);
        int ch;
        bit xfer;
        @(posedge clk); #1;
        m_valid = n_valid; m_data = n_data; m_ovf = n_ovf;
        rst_n = rn;
        bus.ps2_received_data = b;
        bus.ps2_received_data_strb = s;
        bus.ascii_ready = r;
        if (!rn) begin
            n_valid = 0; n_data = 0; n_ovf = 0;
            m_brk = 0; m_ext = 0; m_shift = 0;
            exp_q.delete();
        end else begin
            xfer = m_valid && r;
            ch = s ? model_byte(b) : -1;
            if (xfer) n_valid = 0;
            if (ch >= 0) begin
                if (!m_valid || xfer) begin
                    n_valid = 1; n_data = ch; exp_q.push_back(ch);
                end else n_ovf = 1;
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input bit r);
        cyc(1, b, 1, r);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(1, 8'h00, 0, r);
    endtask

    // Monitor: cycle-exact output checks plus in-order delivery against the scoreboard.
    always @(negedge clk) begin
        if (started) begin
            chk("ascii_valid", int'(bus.ascii_valid), int'(m_valid));
            chk("overflow", int'(bus.overflow), int'(m_ovf));
            chk("ascii_data", int'(bus.ascii_data), m_data);
            if (bus.ascii_valid && bus.ascii_ready && rst_n) begin
                if (exp_q.size() == 0) chk("unexpected_char", int'(bus.ascii_data), -1);
                else chk("delivered_char", int'(bus.ascii_data), exp_q.pop_front());
            end
        end
    end

    initial begin
        int sel;
        logic [7:0] b;
        rst_n = 1'b0;
        bus.ps2_received_data = 8'h00;
        bus.ps2_received_data_strb = 1'b0;
        bus.ascii_ready = 1'b0;
        cyc(0, 8'h00, 0, 0);
        started = 1'b1;
        cyc(0, 8'h1C, 1, 0);
        idle(2, 1);

        send(8'h1C, 1); idle(3, 1);
        send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1); idle(2, 1);
        send(8'hE0, 1); send(8'h75, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1); idle(2, 1);
        send(8'hAA, 1); send(8'hFA, 1); send(8'hFE, 1); send(8'h12, 1); idle(2, 1);
        send(8'h16, 0); idle(2, 0); send(8'h1E, 1); idle(2, 0); idle(2, 1);
        send(8'h16, 0); idle(1, 0); send(8'h1E, 0); idle(2, 0); idle(3, 1);
`ifdef PS2_LOWERCASE_EN
        send(8'h1C, 1); send(8'h12, 1); send(8'h1C, 1); send(8'hF0, 1); send(8'h12, 1);
        send(8'h1C, 1); idle(2, 1);
`endif
        send(8'h1C, 0); send(8'hF0, 0); cyc(0, 8'h1C, 1, 0); cyc(1, 8'h00, 0, 1);
        send(8'h1C, 1); idle(2, 1);

        for (int i = 0; i < 800; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: b = 8'hF0;
                1: b = 8'hE0;
                2: b = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
                3, 4, 5, 6: b = codes[$urandom_range(0, 38)];
                7: b = 8'hAA;
                default: b = 8'($urandom);
            endcase
            if (i == 400) cyc(0, b, 1, 0);
            else cyc(1, b, ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 6));
        end
        idle(4, 1);
        chk("drain_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all logic on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have port: ps2_received_data  input  8  PS/2 set-2 byte from the PS/2 receiver stage.
REQ-004 SHALL have port: ps2_received_data_strb  input  1  byte-valid pulse; data sampled in the same cycle.
REQ-005 SHALL have port: ascii_data  output  8  decoded character.
REQ-006 SHALL have port: ascii_valid  output  1  ascii_data holds an undelivered character.
REQ-007 SHALL have port: ascii_ready  input  1  consumer accepts; transfer when ascii_valid && ascii_ready.
REQ-008 SHALL have port: overflow  output  1  sticky flag; a decoded character was dropped.

Function
REQ-009 SHALL implement FSM states IDLE, BREAK, EXT, EXT_BREAK, advanced only on cycles with ps2_received_data_strb=1.
REQ-010 SHALL transition from IDLE on byte 0xF0 -> BREAK, on 0xE0 -> EXT, on any other byte -> IDLE, treating that byte as a make code.
REQ-011 SHALL transition BREAK -> IDLE on any byte, with no character emitted.
REQ-012 SHALL transition EXT on 0xF0 -> EXT_BREAK and on any other byte -> IDLE, and EXT_BREAK on any byte -> IDLE; extended keys never emit.
REQ-013 SHALL map make codes: A-Z = 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A -> 0x41-0x5A.
REQ-014 SHALL map digits 0-9 = 45,16,1E,26,25,2E,36,3D,3E,46 -> 0x30-0x39; 0x29 -> 0x20 (space); 0x5A -> 0x0D (enter); 0x66 -> 0x08 (backspace).
REQ-015 SHALL discard unmapped make codes (including 0xAA, 0xFA, 0xFE) with no output and no overflow.
REQ-016 SHALL register the output, so a mapped make code strobed in cycle N gives ascii_valid=1 and ascii_data valid in cycle N+1.
REQ-017 SHALL hold ascii_valid and ascii_data stable until the transfer cycle; ascii_valid falls in the following cycle unless reloaded.
REQ-018 SHALL keep ascii_data unchanged while ascii_valid=0.
REQ-019 SHALL drop a new mapped character when the holding register is full and not draining, keep the old ascii_data, and set overflow=1.
REQ-020 SHALL, when transfer and a new mapped character occur in the same cycle, load the new character with ascii_valid staying 1 and no overflow.
REQ-021 SHALL keep overflow at 1 until reset.

Reset
REQ-022 SHALL, on rst_n=0 at a clock edge: state IDLE, ascii_data=0x00, ascii_valid=0, overflow=0, shift state cleared.
REQ-023 SHALL discard a pending character, and any partial break or extended sequence, on reset mid-operation.
REQ-024 SHALL ignore ps2_received_data_strb in any cycle where rst_n=0.

Configuration
REQ-025 SHALL, with PS2_LOWERCASE_EN defined, track shift: make 0x12/0x59 in IDLE sets shift, and break F0 12 / F0 59 clears it.
REQ-026 SHALL, with PS2_LOWERCASE_EN defined, emit letters as 0x61-0x7A when shift=0 and 0x41-0x5A when shift=1; other characters are unaffected.
REQ-027 SHALL, without PS2_LOWERCASE_EN, always emit letters uppercase and implement no shift register; 0x12/0x59 are unmapped.

Verification
REQ-028 SHALL cover: strobe 0x1C, ascii_ready=1 -> ascii_valid=1 and ascii_data=0x41 one cycle later, for exactly one cycle.
REQ-029 SHALL cover: sequence 0x1C, 0xF0, 0x1C -> exactly one character 0x41; sequence 0xE0, 0x75, 0xE0, 0xF0, 0x75 -> no output.
REQ-030 SHALL cover: ascii_ready=0, strobes 0x16 then 0x1E -> ascii_data stays 0x31 and overflow=1; after ready, 0x32 is never seen.
REQ-031 SHALL cover: ascii_valid=1 (0x31), ascii_ready=1 in the same cycle as strobe 0x1E -> next cycle ascii_data=0x32, ascii_valid=1, overflow=0.
REQ-032 SHALL cover: with PS2_LOWERCASE_EN, sequence 0x1C, 0x12, 0x1C, 0xF0, 0x12, 0x1C -> outputs 0x61, 0x41, 0x61.
REQ-033 SHALL cover: rst_n=0 while ascii_valid=1 and state BREAK -> all outputs 0; after reset, 0x1C emits 0x41.
